// File: rtl/hps_cumsum_poll_master.sv
// rtl/hps_cumsum_poll_master.sv - periodic Avalon-MM poller of a cumulative count, emitting value and delta
// Optional feature macro: CUMSUM_POLL_TIMESTAMP_EN adds the sample_ts output.
module hps_cumsum_poll_master #(
    parameter int POLL_DIV = 100,
    parameter int DATA_W   = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] sample_delta,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef CUMSUM_POLL_TIMESTAMP_EN
    ,
    output logic [31:0]       sample_ts
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        CAPT = 2'd3
    } state_t;

    localparam logic [15:0] TCNT_MAX = 16'(POLL_DIV - 1);

    state_t            state;
    state_t            state_next;
    logic [15:0]       tcnt;
    logic              tick;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] new_sample;
    logic              load;
    logic              drop;
    logic              unused_hi;

    assign tick       = enable && (tcnt == TCNT_MAX);
    assign new_sample = avm_readdata[DATA_W-1:0];
    // Bits above DATA_W carry other PIO fields and are deliberately ignored.
    assign unused_hi  = ^(avm_readdata >> DATA_W);

    // Load when the output slot is free or being drained this cycle; otherwise the new sample is lost.
    assign load = (state == CAPT) && (!sample_valid || sample_ready);
    assign drop = (state == CAPT) && sample_valid && !sample_ready;

    // Poll period counter, parked at zero while polling is disabled.
    always_ff @(posedge clk) begin
        if (reset || !enable || tick) begin
            tcnt <= 16'd0;
        end else begin
            tcnt <= tcnt + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus strobe decode; the read is issued only from READ.
    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = 2'd0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (tick) begin
                    state_next = READ;
                end
            end
            READ: begin
                avm_read   = 1'b1;
                state_next = CAPT;
            end
            CAPT: begin
                state_next = enable ? WAIT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register and delta tracking; prev only advances on accepted samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            sample_data  <= '0;
            sample_delta <= '0;
            sample_valid <= 1'b0;
        end else if (load) begin
            sample_data  <= new_sample;
            sample_delta <= new_sample - prev;
            prev         <= new_sample;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef CUMSUM_POLL_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter, latched with each accepted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt    <= 32'd0;
            sample_ts <= 32'd0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (load) begin
                sample_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hps_cumsum_poll_master.sv
// tb/tb_hps_cumsum_poll_master.sv - scoreboard bench for hps_cumsum_poll_master
module tb_hps_cumsum_poll_master;

    localparam int POLL_DIV = 4;
    localparam int DATA_W   = 28;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic [31:0]       avm_readdata;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] sample_delta;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              overrun_clr;
`ifdef CUMSUM_POLL_TIMESTAMP_EN
    logic [31:0]       sample_ts;
    logic [31:0]       ts_last;
    logic [31:0]       ts_prev;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int read_cycles = 0;
    int pop_cyc_last = 0;
    int pop_cyc_prev = 0;
    int pops = 0;
    int rc0;

    logic [DATA_W-1:0] slave_count;
    logic [2*DATA_W-1:0] exp_q[$];

    hps_cumsum_poll_master #(.POLL_DIV(POLL_DIV), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .sample_data(sample_data),
        .sample_delta(sample_delta),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
`ifdef CUMSUM_POLL_TIMESTAMP_EN
        ,
        .sample_ts(sample_ts)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input-PIO slave: one-cycle read latency, junk in upper bits and when idle.
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= {4'hA, slave_count};
        else          avm_readdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Output monitor: pop and compare on every handshake, count read strobes.
    always @(negedge clk) begin
        logic [2*DATA_W-1:0] e;
        #1;
        if (avm_read) read_cycles++;
        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", {4'h0, sample_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sample_data", {4'h0, sample_data}, {4'h0, e[2*DATA_W-1:DATA_W]});
                check("sample_delta", {4'h0, sample_delta}, {4'h0, e[DATA_W-1:0]});
            end
            pop_cyc_prev = pop_cyc_last;
            pop_cyc_last = cyc;
            pops++;
`ifdef CUMSUM_POLL_TIMESTAMP_EN
            ts_prev = ts_last;
            ts_last = sample_ts;
`endif
        end
    end

    task automatic wait_read();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_read) break;
        end
        check("read_issued", {31'd0, avm_read}, 32'd1);
        check("read_address", {30'd0, avm_address}, 32'd0);
    endtask

    // One poll with the slave showing cnt; returns in the capture cycle.
    task automatic poll(input logic [DATA_W-1:0] cnt, input logic [DATA_W-1:0] dlt, input bit expect_out);
        slave_count = cnt;
        if (expect_out) exp_q.push_back({cnt, dlt});
        enable = 1'b1;
        wait_read();
        @(negedge clk);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) break;
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, {4'h0, sample_data}, 32'd0);
        check({tag, "_delta"}, {4'h0, sample_delta}, 32'd0);
        check({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, "_read"}, {31'd0, avm_read}, 32'd0);
        check({tag, "_address"}, {30'd0, avm_address}, 32'd0);
`ifdef CUMSUM_POLL_TIMESTAMP_EN
        check({tag, "_ts"}, sample_ts, 32'd0);
`endif
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        slave_count  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic poll: back-to-back samples 10 then 25.
        #2 rc0 = read_cycles;
        poll(28'd10, 28'd10, 1'b1);
        poll(28'd25, 28'd15, 1'b1);
        enable = 1'b0;
        wait_empty();
        check("basic_spacing", pop_cyc_last - pop_cyc_prev, 32'd4);
        check("basic_read_cycles", read_cycles - rc0, 32'd2);
`ifdef CUMSUM_POLL_TIMESTAMP_EN
        check("ts_spacing", ts_last - ts_prev, 32'd4);
`endif
        @(negedge clk);

        // Backpressure: 40 is held, 55 is dropped.
        sample_ready = 1'b0;
        poll(28'd40, 28'd15, 1'b1);
        poll(28'd55, 28'd0, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        check("bp_overrun_set", {31'd0, overrun}, 32'd1);
        check("bp_held_valid", {31'd0, sample_valid}, 32'd1);
        check("bp_held_data", {4'h0, sample_data}, 32'd40);
        check("bp_held_delta", {4'h0, sample_delta}, 32'd15);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("bp_overrun_clr", {31'd0, overrun}, 32'd0);
        check("bp_still_data", {4'h0, sample_data}, 32'd40);
        sample_ready = 1'b1;
        wait_empty();
        @(negedge clk);

        // Delta spans the dropped sample, then wrap-around.
        poll(28'd60, 28'd20, 1'b1);
        poll(28'hFFFFFFE, 28'hFFFFFC2, 1'b1);
        poll(28'h0000003, 28'h0000005, 1'b1);
        enable = 1'b0;
        wait_empty();
        @(negedge clk);

        // Enable falls while the read is on the bus.
        slave_count = 28'd100;
        exp_q.push_back({28'd100, 28'd97});
        enable = 1'b1;
        wait_read();
        enable = 1'b0;
        #2 rc0 = read_cycles;
        wait_empty();
        repeat (20) @(negedge clk);
        #2 check("no_read_after_disable", read_cycles - rc0, 32'd0);

        // Reset in CAPT with a sample pending.
        sample_ready = 1'b0;
        poll(28'd200, 28'd0, 1'b0);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        sample_ready = 1'b1;
        @(negedge clk);
        poll(28'd7, 28'd7, 1'b1);
        enable = 1'b0;
        wait_empty();

        repeat (3) @(negedge clk);
        #2 check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hps_cumsum_poll_master.md
HPS_CUMSUM_POLL_MASTER -- requirements
Module: hps_cumsum_poll_master

Interface
REQ-001 SHALL have parameter POLL_DIV, default 100: poll period in clk cycles; legal range 3..65535.
REQ-002 SHALL have parameter DATA_W, default 28: width of the sampled count held in the low bits of avm_readdata.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous to clk and active-high.
REQ-005 SHALL have port enable, input, 1: high starts and continues polling.
REQ-006 SHALL have port avm_address, output, 2: Avalon-MM read address to the input-PIO slave.
REQ-007 SHALL have port avm_read, output, 1: Avalon-MM read strobe.
REQ-008 SHALL have port avm_readdata, input, 32: slave read data; fixed read latency of 1 cycle; no waitrequest.
REQ-009 SHALL have port sample_data, output, DATA_W: last accepted count.
REQ-010 SHALL have port sample_delta, output, DATA_W: sample_data minus the previously loaded sample, mod 2^DATA_W.
REQ-011 SHALL have port sample_valid, output, 1: output stream valid.
REQ-012 SHALL have port sample_ready, input, 1: output stream ready.
REQ-013 SHALL have port overrun, output, 1: sticky flag, set when a sample is dropped.
REQ-014 SHALL have port overrun_clr, input, 1: single-cycle clear for overrun.

Function
REQ-015 SHALL contain tick counter tcnt (16 bit): counts 0..POLL_DIV-1 while enable=1; held at 0 while enable=0; tick is asserted in the cycle tcnt=POLL_DIV-1, after which tcnt wraps to 0.
REQ-016 SHALL implement FSM states IDLE, WAIT, READ, CAPT: IDLE->WAIT on enable=1; WAIT->READ on tick; READ->CAPT unconditionally; CAPT->WAIT if enable=1, else CAPT->IDLE; WAIT->IDLE on enable=0.
REQ-017 SHALL drive avm_read=1 and avm_address=0 only in READ; avm_read=0 and avm_address=0 in all other states.
REQ-018 SHALL sample avm_readdata[DATA_W-1:0] in CAPT; bits above DATA_W are ignored.
REQ-019 SHALL load the output register in CAPT when (sample_valid=0 or sample_ready=1): sample_data<=new, sample_delta<=new-prev, prev<=new, sample_valid<=1.
REQ-020 SHALL drop the new sample and set overrun when in CAPT sample_valid=1 and sample_ready=0; prev is unchanged, so the next delta spans the dropped sample.
REQ-021 SHALL clear sample_valid on a cycle with sample_valid=1, sample_ready=1 and no load in that cycle; sample_data and sample_delta SHALL stay stable while sample_valid=1 and sample_ready=0.
REQ-022 SHALL have latency tick cycle T -> avm_read at T+1 -> CAPT at T+2 -> sample_valid=1 at T+3.
REQ-023 SHALL complete a read already issued when enable falls during READ, loading the sample per REQ-019/020.
REQ-024 SHALL give overrun_clr and a same-cycle overrun set the set priority.
REQ-025 SHALL compute the subtraction modulo 2^DATA_W (wrap-around), e.g. prev=0xFFFFFFE, new=0x0000003 -> delta=0x0000005.

Reset
REQ-026 SHALL on reset=1 at a clk edge: state=IDLE, tcnt=0, prev=0, sample_data=0, sample_delta=0, sample_valid=0, overrun=0, avm_read=0, avm_address=0; the timestamp counter is also cleared when present.
REQ-027 SHALL abandon any in-flight read on reset asserted mid-operation; the response in the next cycle is not captured.

Configuration
REQ-028 SHALL, when CUMSUM_POLL_TIMESTAMP_EN is defined, add output port sample_ts (32 bit): a free-running cycle counter latched alongside sample_data on each load, wrapping at 2^32.
REQ-029 SHALL, when CUMSUM_POLL_TIMESTAMP_EN is undefined, omit the sample_ts port and its counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover basic poll: POLL_DIV=4, enable=1, sample_ready=1, slave count 10 then 25 -> samples (10, delta 10), then (25, delta 15), spaced 4 cycles; avm_read high exactly 1 cycle per poll.
REQ-031 SHALL cover backpressure: sample_ready=0 across two polls -> first sample held stable, second dropped, overrun=1; overrun_clr pulse -> overrun=0.
REQ-032 SHALL cover wrap: prev=0xFFFFFFE, next read 0x0000003 -> sample_delta=0x0000005.
REQ-033 SHALL cover enable drop during READ: the read completes, the sample is delivered, FSM goes to IDLE, and no further avm_read occurs.
REQ-034 SHALL cover reset mid-CAPT with a pending sample: all outputs are 0 on the next cycle and the first post-reset delta equals the sample value.
REQ-035 SHALL cover the timestamp build: with CUMSUM_POLL_TIMESTAMP_EN defined and POLL_DIV=4, consecutive sample_ts values differ by exactly 4.
